vga_fb_write_ctrl: RTL and testbench
====================================

Name: vga_fb_write_ctrl

Overview:
- Write-side controller for the 256x256 framebuffer RAM. Drives the RAM write port only. The VGA scan-out owns the read port.
- Shares the single write port between two requesters:
  - CPU single-pixel stores, using a valid/ready handshake.
  - A built-in rectangle-fill engine, started with one pulse.
- Sits between the CPU bus bridge and the framebuffer RAM, in the write_clock domain.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- X_BITS, 8, bits of x coordinate (framebuffer width = 2**X_BITS).
- Y_BITS, 8, bits of y coordinate (framebuffer height = 2**Y_BITS).

Ports:
- clock  in  1  write_clock of the framebuffer; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_valid  in  1  CPU pixel store pending.
- cpu_x  in  X_BITS  CPU pixel x.
- cpu_y  in  Y_BITS  CPU pixel y.
- cpu_data  in  DATA_WIDTH  CPU pixel value.
- cpu_ready  out  1  combinational; the store is accepted in any cycle where cpu_valid && cpu_ready.
- fill_start  in  1  one-cycle pulse that starts a fill.
- fill_x0  in  X_BITS  rectangle origin x.
- fill_y0  in  Y_BITS  rectangle origin y.
- fill_w  in  X_BITS+1  rectangle width, 0..2**X_BITS.
- fill_h  in  Y_BITS+1  rectangle height, 0..2**Y_BITS.
- fill_color  in  DATA_WIDTH  fill value.
- fill_busy  out  1  fill engine active.
- fill_done  out  1  one-cycle pulse when a fill completes.
- fb_we  out  1  RAM write enable, registered.
- fb_addr  out  X_BITS+Y_BITS  RAM write address {y,x}, registered.
- fb_wdata  out  DATA_WIDTH  RAM write data, registered.

Behaviour:
- Reset (asynchronous, on reset_n low):
  - fb_we=0, fb_addr=0, fb_wdata=0.
  - fill_busy=0, fill_done=0.
  - FSM=IDLE, last_grant=FILL.
  - Reset takes effect immediately mid-fill. No further writes occur, and fill_done does not pulse.
- Address: fb_addr = {y, x}, i.e. y*2**X_BITS + x.
- Write latency: a request granted in cycle n produces fb_we=1, fb_addr and fb_wdata in cycle n+1. fb_we=0 in any cycle following a cycle with no grant.
- Fill FSM states: IDLE, RUN, DONE.
  - IDLE, fill_start=1:
    - Latch x0, y0, w, h and color; clear the cx/cy offset counters.
    - If w==0 or h==0, go to DONE (no writes). Otherwise go to RUN.
  - IDLE, fill_start=0: stay.
  - RUN:
    - Each fill grant writes pixel ((x0+cx) mod 2**X_BITS, (y0+cy) mod 2**Y_BITS). The wrap is modular, with no clipping.
    - Then cx increments. When cx==w-1, cx returns to 0 and cy increments (row-major).
    - After the grant with cx==w-1 and cy==h-1, go to DONE.
  - DONE: fill_done=1 for exactly one cycle, then IDLE.
  - fill_done coincides with fb_we of the last fill pixel.
  - fill_busy=1 in RUN and DONE, 0 in IDLE.
- fill_start while busy: ignored (no relatch). fill_start in the DONE cycle is also ignored.
- Arbitration (evaluated each cycle):
  - FSM not in RUN: cpu_ready=1.
  - RUN and cpu_valid=0: fill granted.
  - RUN and cpu_valid=1: alternate. The CPU is granted if last_grant==FILL, otherwise fill is granted.
  - last_grant updates on every grant.
  - Guarantee: neither requester waits more than 1 cycle while both are pending.
- cpu_ready does not depend on cpu_valid in a way that creates a loop. It is a function of the FSM state and last_grant only.
- Full-screen fill: w=2**X_BITS, h=2**Y_BITS writes 65536 pixels. It takes exactly 65536 cycles with no CPU traffic.
- Width arithmetic: cx and cy counters are X_BITS+1 and Y_BITS+1 bits wide, so w=256 and h=256 terminate correctly.

Test Plan:
- Reset, then cpu_valid=1, x=3, y=2, data=0xA5 with no fill active -> cpu_ready=1; next cycle fb_we=1, fb_addr=0x0203, fb_wdata=0xA5.
- fill_start with x0=10, y0=20, w=3, h=2, color=0x3C, no CPU traffic:
  - fb_we is high for 6 consecutive cycles.
  - Addresses in order: 0x140A, 0x140B, 0x140C, 0x150A, 0x150B, 0x150C.
  - fill_done pulses with the 6th write; fill_busy falls the next cycle.
- Fill w=4, h=1 at (0,0) with cpu_valid held high (x=0xFF, y=0xFF):
  - Writes alternate CPU(0xFFFF) / fill(0x0000) / CPU / fill(0x0001) ... until all 4 fill pixels are done.
  - cpu_ready toggles each cycle during the fill.
- Wrap: x0=0xFE, y0=0xFF, w=3, h=2 -> addresses 0xFFFE, 0xFFFF, 0xFF00, 0x00FE, 0x00FF, 0x0000.
- w=0, h=5 -> no fb_we; fill_busy=1 for one cycle with fill_done=1 in that cycle. A second fill_start during a running fill is ignored: the write count is unchanged.
- Assert reset_n low mid-fill (after 3 of 6 pixels) -> fb_we=0 immediately, fill_busy=0, no fill_done. After release, a CPU write is accepted normally.

Source files
------------

// File: rtl/vga_fb_write_ctrl.sv
// ============================================================================
//  Module   : vga_fb_write_ctrl
//  Brief    : Framebuffer write-port controller sharing the RAM write port
//             between CPU pixel stores and a rectangle-fill engine.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module vga_fb_write_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int X_BITS     = 8,
    parameter int Y_BITS     = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     cpu_valid,
    input  logic [X_BITS-1:0]        cpu_x,
    input  logic [Y_BITS-1:0]        cpu_y,
    input  logic [DATA_WIDTH-1:0]    cpu_data,
    output logic                     cpu_ready,
    input  logic                     fill_start,
    input  logic [X_BITS-1:0]        fill_x0,
    input  logic [Y_BITS-1:0]        fill_y0,
    input  logic [X_BITS:0]          fill_w,
    input  logic [Y_BITS:0]          fill_h,
    input  logic [DATA_WIDTH-1:0]    fill_color,
    output logic                     fill_busy,
    output logic                     fill_done,
    output logic                     fb_we,
    output logic [X_BITS+Y_BITS-1:0] fb_addr,
    output logic [DATA_WIDTH-1:0]    fb_wdata
);

    localparam logic [X_BITS:0] c_ONE_X = 1;
    localparam logic [Y_BITS:0] c_ONE_Y = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic                       last_cpu_q, last_cpu_d;
    logic [X_BITS-1:0]          x0_q, x0_d;
    logic [Y_BITS-1:0]          y0_q, y0_d;
    logic [X_BITS:0]            w_q, w_d;
    logic [Y_BITS:0]            h_q, h_d;
    logic [DATA_WIDTH-1:0]      color_q, color_d;
    logic [X_BITS:0]            cx_q, cx_d;
    logic [Y_BITS:0]            cy_q, cy_d;
    logic                       fb_we_q, fb_we_d;
    logic [X_BITS+Y_BITS-1:0]   fb_addr_q, fb_addr_d;
    logic [DATA_WIDTH-1:0]      fb_wdata_q, fb_wdata_d;

    logic                       grant_cpu;
    logic                       grant_fill;
    logic [X_BITS-1:0]          fill_x;
    logic [Y_BITS-1:0]          fill_y;

    // Ready depends only on state and last grant, never on cpu_valid.
    assign cpu_ready  = (state_q != S_RUN) || !last_cpu_q;
    assign grant_cpu  = cpu_valid && cpu_ready;
    assign grant_fill = (state_q == S_RUN) && !grant_cpu;

    // Coordinates wrap modulo the framebuffer size by truncation.
    assign fill_x = x0_q + cx_q[X_BITS-1:0];
    assign fill_y = y0_q + cy_q[Y_BITS-1:0];

    always_comb begin
        state_d    = state_q;
        last_cpu_d = last_cpu_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        w_d        = w_q;
        h_d        = h_q;
        color_d    = color_q;
        cx_d       = cx_q;
        cy_d       = cy_q;

        case (state_q)
            S_IDLE: begin
                if (fill_start) begin
                    x0_d    = fill_x0;
                    y0_d    = fill_y0;
                    w_d     = fill_w;
                    h_d     = fill_h;
                    color_d = fill_color;
                    cx_d    = '0;
                    cy_d    = '0;
                    if ((fill_w == '0) || (fill_h == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (grant_fill) begin
                    if (cx_q == (w_q - c_ONE_X)) begin
                        cx_d = '0;
                        if (cy_q == (h_q - c_ONE_Y)) begin
                            state_d = S_DONE;
                        end else begin
                            cy_d = cy_q + c_ONE_Y;
                        end
                    end else begin
                        cx_d = cx_q + c_ONE_X;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (grant_cpu) begin
            last_cpu_d = 1'b1;
        end else if (grant_fill) begin
            last_cpu_d = 1'b0;
        end
    end

    always_comb begin
        fb_we_d    = grant_cpu || grant_fill;
        fb_addr_d  = fb_addr_q;
        fb_wdata_d = fb_wdata_q;
        if (grant_cpu) begin
            fb_addr_d  = {cpu_y, cpu_x};
            fb_wdata_d = cpu_data;
        end else if (grant_fill) begin
            fb_addr_d  = {fill_y, fill_x};
            fb_wdata_d = color_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            last_cpu_q <= 1'b0;
            x0_q       <= '0;
            y0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            color_q    <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            last_cpu_q <= last_cpu_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            w_q        <= w_d;
            h_q        <= h_d;
            color_q    <= color_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            fb_we_q    <= fb_we_d;
            fb_addr_q  <= fb_addr_d;
            fb_wdata_q <= fb_wdata_d;
        end
    end

    // The last fill pixel's write lands in the DONE cycle, so done aligns with it.
    assign fill_busy = (state_q != S_IDLE);
    assign fill_done = (state_q == S_DONE);
    assign fb_we     = fb_we_q;
    assign fb_addr   = fb_addr_q;
    assign fb_wdata  = fb_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_fb_write_ctrl.sv
// ============================================================================
//  Module   : tb_vga_fb_write_ctrl
//  Brief    : Scoreboard bench for vga_fb_write_ctrl with a pixel-index model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vga_fb_write_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_valid = 1'b0;
    logic [7:0]  cpu_x = '0;
    logic [7:0]  cpu_y = '0;
    logic [7:0]  cpu_data = '0;
    logic        cpu_ready;
    logic        fill_start = 1'b0;
    logic [7:0]  fill_x0 = '0;
    logic [7:0]  fill_y0 = '0;
    logic [8:0]  fill_w = '0;
    logic [8:0]  fill_h = '0;
    logic [7:0]  fill_color = '0;
    logic        fill_busy;
    logic        fill_done;
    logic        fb_we;
    logic [15:0] fb_addr;
    logic [7:0]  fb_wdata;

    vga_fb_write_ctrl #(.DATA_WIDTH(8), .X_BITS(8), .Y_BITS(8)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cpu_valid  (cpu_valid),
        .cpu_x      (cpu_x),
        .cpu_y      (cpu_y),
        .cpu_data   (cpu_data),
        .cpu_ready  (cpu_ready),
        .fill_start (fill_start),
        .fill_x0    (fill_x0),
        .fill_y0    (fill_y0),
        .fill_w     (fill_w),
        .fill_h     (fill_h),
        .fill_color (fill_color),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_wdata   (fb_wdata)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int c;
        int addr;
        int data;
    } wr_t;
    wr_t q[$];

    // Abstract model: fill progress is a single pixel index k over w*h pixels.
    int m_state = 0;   // 0 idle, 1 filling, 2 done-cycle
    bit m_last_cpu = 1'b0;
    int m_x0, m_y0, m_w, m_h, m_col, m_k;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin : model
        bit exp_ready, g_cpu, g_fill;
        wr_t e;
        if (!reset_n) begin
            chk("rst_we", int'(fb_we), 0);
            chk("rst_busy", int'(fill_busy), 0);
            chk("rst_done", int'(fill_done), 0);
            chk("rst_addr", int'(fb_addr), 0);
            chk("rst_wdata", int'(fb_wdata), 0);
            q.delete();
            m_state    = 0;
            m_last_cpu = 1'b0;
        end else begin
            exp_ready = (m_state != 1) || !m_last_cpu;
            chk("cpu_ready", int'(cpu_ready), int'(exp_ready));
            chk("fill_busy", int'(fill_busy), int'(m_state != 0));
            chk("fill_done", int'(fill_done), int'(m_state == 2));
            g_cpu  = cpu_valid && exp_ready;
            g_fill = (m_state == 1) && !g_cpu;
            if (g_cpu) begin
                e.c = cyc + 1;
                e.addr = int'(cpu_y) * 256 + int'(cpu_x);
                e.data = int'(cpu_data);
                q.push_back(e);
                m_last_cpu = 1'b1;
            end
            case (m_state)
                0: begin
                    if (fill_start) begin
                        m_x0 = int'(fill_x0);
                        m_y0 = int'(fill_y0);
                        m_w  = int'(fill_w);
                        m_h  = int'(fill_h);
                        m_col = int'(fill_color);
                        m_k  = 0;
                        m_state = (m_w * m_h == 0) ? 2 : 1;
                    end
                end
                1: begin
                    if (g_fill) begin
                        e.c = cyc + 1;
                        e.addr = ((m_y0 + m_k / m_w) % 256) * 256 + (m_x0 + m_k % m_w) % 256;
                        e.data = m_col;
                        q.push_back(e);
                        m_last_cpu = 1'b0;
                        m_k++;
                        if (m_k == m_w * m_h) m_state = 2;
                    end
                end
                default: m_state = 0;
            endcase
        end
    end

    always @(negedge clock) begin : monitor
        wr_t e;
        if (reset_n) begin
            if (fb_we) begin
                if (q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("wr_cycle", cyc, e.c);
                    chk("wr_addr", int'(fb_addr), e.addr);
                    chk("wr_data", int'(fb_wdata), e.data);
                end
            end else if (q.size() > 0 && q[0].c <= cyc) begin
                chk("missing_write", 0, 1);
                void'(q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_fill(input int x0, input int y0, input int w, input int h, input int col);
        fill_x0    = 8'(x0);
        fill_y0    = 8'(y0);
        fill_w     = 9'(w);
        fill_h     = 9'(h);
        fill_color = 8'(col);
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (fill_busy && n < budget) begin
            tick();
            n++;
        end
        chk("fill_timeout", int'(fill_busy), 0);
    endtask

    task automatic cpu_write(input int x, input int y, input int d);
        cpu_valid = 1'b1;
        cpu_x     = 8'(x);
        cpu_y     = 8'(y);
        cpu_data  = 8'(d);
        tick();
        cpu_valid = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        cpu_write(3, 2, 'hA5);
        repeat (2) tick();

        start_fill(10, 20, 3, 2, 'h3C);
        wait_idle(100);
        tick();

        // CPU held pending through the whole fill: grants must alternate.
        cpu_valid = 1'b1;
        cpu_x = 8'hFF;
        cpu_y = 8'hFF;
        cpu_data = 8'h5A;
        start_fill(0, 0, 4, 1, 'h77);
        wait_idle(100);
        cpu_valid = 1'b0;
        tick();

        start_fill('hFE, 'hFF, 3, 2, 'hC3);
        wait_idle(100);
        start_fill(0, 0, 0, 5, 'h11);
        wait_idle(100);
        tick();

        start_fill(1, 1, 3, 2, 'h22);
        tick();
        start_fill(50, 50, 5, 5, 'h99);
        wait_idle(100);
        tick();

        start_fill(5, 5, 3, 2, 'h44);
        repeat (3) tick();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        cpu_write(7, 9, 'h6E);
        repeat (2) tick();

        for (int i = 0; i < 30; i++) begin
            int n;
            cpu_valid = 1'($urandom_range(0, 1));
            cpu_x     = 8'($urandom);
            cpu_y     = 8'($urandom);
            cpu_data  = 8'($urandom);
            start_fill(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                       int'($urandom_range(0, 255)));
            n = 0;
            while (fill_busy && n < 200) begin
                cpu_valid  = 1'($urandom_range(0, 1));
                cpu_x      = 8'($urandom);
                cpu_y      = 8'($urandom);
                cpu_data   = 8'($urandom);
                fill_start = ($urandom_range(0, 7) == 0);
                fill_x0    = 8'($urandom);
                fill_w     = 9'($urandom_range(1, 4));
                tick();
                n++;
            end
            chk("rand_fill_timeout", int'(fill_busy), 0);
            cpu_valid  = 1'b0;
            fill_start = 1'b0;
            tick();
        end

        start_fill(0, 0, 256, 256, 'hEE);
        wait_idle(70000);
        repeat (3) tick();
        chk("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
